// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic push_acc;
  logic pop_acc;

  // Status flags decode straight from the registered count.
  always_comb begin
    full         = (count_q == CW'(DEPTH));
    empty        = (count_q == '0);
    almost_full  = (count_q >= CW'(AF_LEVEL));
    almost_empty = (count_q <= CW'(AE_LEVEL));
  end

  // Acceptance: a pop frees a slot, so push into a full FIFO is taken alongside it.
  always_comb begin
    pop_acc  = pop & ~empty;
    push_acc = push & (~full | pop_acc);
  end

  // Next-state for pointers, count and sticky error flags.
  always_comb begin
    wr_ptr_d    = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop_acc  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q;
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    overflow_d  = overflow_q  | (push & ~push_acc);
    underflow_d = underflow_q | (pop & ~pop_acc);
    // Clear wins over a set in the same cycle.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  // Control state with asynchronous reset; stored entries are discarded by
  // zeroing the count and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Output drive: head entry falls through combinationally.
  always_comb begin
    rdata      = mem[rd_ptr_q];
    fifo_count = count_q;
    overflow   = overflow_q;
    underflow  = underflow_q;
  end

  // Accepted-transfer sanity checks; these only observe and never steer logic.
  always @(posedge clk) begin
    if (rst_n) begin
      a_fifomax: assert (!(push_acc && !pop_acc) || (count_q < CW'(DEPTH)))
        else $error("%m: push into full FIFO at %0t, fifo_count=%0d", $time, count_q);
      a_fifomin: assert (!(pop_acc && !push_acc) || (count_q > '0))
        else $error("%m: pop from empty FIFO at %0t, fifo_count=%0d", $time, count_q);
    end
  end

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));

  a_full_empty: assert property (@(posedge clk) disable iff (!rst_n) !(full && empty));

  // Skip the first edge after a reset release, where the count may jump to 0.
  a_count_step: assert property (@(posedge clk) disable iff (!rst_n)
    $past(rst_n) |-> ((count_q == $past(count_q)) ||
                      (count_q == $past(count_q) + CW'(1)) ||
                      (count_q + CW'(1) == $past(count_q))));

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_sync_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = DEPTH - 2;
  localparam int unsigned AE    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] rdata;
  logic [4:0]       fifo_count;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .pop          (pop),
    .wdata        (wdata),
    .clr_err      (clr_err),
    .rdata        (rdata),
    .fifo_count   (fifo_count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: FIFO contents as a queue plus sticky flags.
  logic [WIDTH-1:0] mq[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      bit do_pop, do_push, n_ovf, n_udf;
      do_pop  = pop && (mq.size() > 0);
      do_push = push && ((mq.size() < DEPTH) || do_pop);
      n_ovf   = m_ovf || (push && !do_push);
      n_udf   = m_udf || (pop && !do_pop);
      if (clr_err) begin
        n_ovf = 1'b0;
        n_udf = 1'b0;
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(wdata);
      m_ovf = n_ovf;
      m_udf = n_udf;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("m_count", 32'(fifo_count), 32'(mq.size()));
      check("m_empty", 32'(empty), 32'(mq.size() == 0));
      check("m_full", 32'(full), 32'(mq.size() == DEPTH));
      check("m_afull", 32'(almost_full), 32'(mq.size() >= AF));
      check("m_aempty", 32'(almost_empty), 32'(mq.size() <= AE));
      check("m_overflow", 32'(overflow), 32'(m_ovf));
      check("m_underflow", 32'(underflow), 32'(m_udf));
      if (mq.size() > 0) check("m_rdata", 32'(rdata), 32'(mq[0]));
    end
  end

  // Drive one cycle of inputs, then settle just after the edge.
  task automatic step(input bit p, input bit q, input logic [WIDTH-1:0] d, input bit c);
    push    = p;
    pop     = q;
    wdata   = d;
    clr_err = c;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    check("rst_afull", 32'(almost_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_udf", 32'(underflow), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Fill with 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0);
      check("fill_afull", 32'(almost_full), 32'(i >= 13));
    end
    check("fill_count", 32'(fifo_count), 32'd16);
    check("fill_full", 32'(full), 32'd1);
    check("fill_rdata", 32'(rdata), 32'h00);

    // Overflow, then drain in order.
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(fifo_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("drain_rdata", 32'(rdata), 32'(i));
      step(1'b0, 1'b1, 8'h00, 1'b0);
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Underflow and clear.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("udf_flag", 32'(underflow), 32'd1);
    check("udf_count", 32'(fifo_count), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("clr_udf", 32'(underflow), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);

    // Push and pop together while empty.
    step(1'b1, 1'b1, 8'h55, 1'b0);
    check("pp_empty_count", 32'(fifo_count), 32'd1);
    check("pp_empty_rdata", 32'(rdata), 32'h55);
    check("pp_empty_udf", 32'(underflow), 32'd1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("pp_empty_drain", 32'(fifo_count), 32'd0);

    // Clear beats a same-cycle underflow set.
    step(1'b0, 1'b1, 8'h00, 1'b1);
    check("clr_priority", 32'(underflow), 32'd0);

    // Steady state at count 8 with simultaneous push/pop; pointers wrap.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      check("pp_rdata", 32'(rdata), 32'(8'h10 + i));
      step(1'b1, 1'b1, 8'(8'h18 + i), 1'b0);
      check("pp_count", 32'(fifo_count), 32'd8);
    end
    check("pp_head", 32'(rdata), 32'h24);

    // Asynchronous reset mid-operation at count 5.
    repeat (3) step(1'b0, 1'b1, 8'h00, 1'b0);
    check("pre_rst_count", 32'(fifo_count), 32'd5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(fifo_count), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_aempty", 32'(almost_empty), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h33, 1'b0);
    check("post_rst_count", 32'(fifo_count), 32'd1);
    check("post_rst_rdata", 32'(rdata), 32'h33);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
